mest_pro_exec_mc: RTL and testbench
===================================

Name: mest_pro_exec_mc

Overview:
- Multi-cycle, parametrised execute unit for the MESTPro core; next generation of the single-cycle execute stage.
- Sits between decode and the register/memory/output subsystem.
- Adds a valid/ready instruction handshake, an iterative shift-add multiplier, and a req/ack main-memory port with timeout.
- Adds an internal memory data register (MDR), a halted state, and width-correct flags.

Parameters:
- DATA_W, 8, datapath and operand width
- ADDR_W, 2*DATA_W, memory address width; address = {operand1, operand2}
- OPC_W, 5, opcode width; encodings per opcodes.vh (OP_ADD, OP_SUB, OP_MULTIPLY, OP_AND, OP_OR, OP_XOR, OP_SROP1, OP_SLOP1, OP_NEGOP1, OP_JMP, OP_RET, OP_MVI, OP_MRA, OP_MLR, OP_MMDR, OP_MRR, OP_OUTPUT, OP_STORE_WORD, OP_LOAD_WORD, OP_HALT)
- MEM_TIMEOUT, 16, cycles without ack before a memory access aborts

Ports:
- clk  in  1  clock
- i_reset_n  in  1  reset
- i_valid  in  1  instruction valid
- o_ready  out  1  unit can accept an instruction
- i_op_code  in  OPC_W  opcode
- i_operand1  in  DATA_W  operand A / address high
- i_operand2  in  DATA_W  operand B / destination select / address low
- i_load_reg  in  DATA_W  load-register value for OP_MLR
- o_done  out  1  one-cycle pulse, instruction retired
- o_result  out  DATA_W  ALU result register
- o_carry  out  1  carry / borrow / overflow flag
- o_zero  out  1  zero flag
- o_jump, o_return_pc, o_end_of_code  out  1 each  one-cycle pulses coincident with o_done
- o_output_enable  out  1  one-cycle pulse on OP_OUTPUT retire
- o_output  out  DATA_W  output register
- o_rega  out  DATA_W  register A
- o_mdr  out  DATA_W  memory data register
- o_mem_req, o_mem_we  out  1 each  memory request; write when o_mem_we=1
- o_mem_addr  out  ADDR_W  memory address
- o_mem_wdata  out  DATA_W  equals o_mdr
- i_mem_ack  in  1  memory acknowledge
- i_mem_rdata  in  DATA_W  read data, valid with ack
- o_bus_err  out  1  one-cycle pulse on memory timeout

Behaviour:
- Reset (already decided): reset i_reset_n, asynchronous, active-low; clock clk.
- Reset mid-operation aborts the current instruction, drops o_mem_req at once and returns the unit to IDLE.
- Reset values: all registers and outputs 0; o_ready=1 (IDLE).
- States: IDLE, MUL, MEM, HALTED. o_ready=1 only in IDLE.
- An instruction is accepted when i_valid && o_ready. i_valid is ignored in every other state.

Single-cycle ops (accepted in IDLE):
- Results, flags and pulses register at the next edge; o_done is high the following cycle; the unit stays IDLE.
- Throughput is 1 per cycle.

Flag rules (updated only by ALU ops and MUL; all other ops preserve them):
- ADD: carry = bit DATA_W of the sum.
- SUB: carry = borrow (op1<op2).
- AND/OR/XOR/NEG: carry=0.
- SLOP1: carry = op1[MSB]. SROP1: carry = op1[0].
- zero = (o_result==0).

Moves (destination selected by operand2: OUTPUT_REG, REGA, MM=MDR; other codes are a no-op but still retire):
- MVI: source is op1.
- MRA: source is rega.
- MLR: source is i_load_reg.
- MMDR: source is MDR (to OUTPUT or REGA).
- MRR: source is o_result.

Control ops:
- JMP, RET, OUTPUT: pulse the matching output with o_done.
- HALT: pulses o_end_of_code and o_done, then enters HALTED. HALTED holds until reset with o_ready=0.
- Unknown opcode: o_done only, no state change.

MUL:
- Latch the operands, clear the accumulator, count=0, then add one shift-add bit per cycle for DATA_W cycles.
- Then o_result = product[DATA_W-1:0], carry = |product[2*DATA_W-1:DATA_W], zero = (full product==0).
- o_done is high exactly DATA_W+1 cycles after acceptance; the unit returns to IDLE the same cycle.

MEM (LOAD_WORD / STORE_WORD):
- On acceptance, register the address and o_mem_we (1 = store), and assert o_mem_req the next cycle.
- Hold req, addr and we stable until an edge samples i_mem_ack=1. Req drops after that edge.
- Load: MDR = i_mem_rdata.
- o_done pulses the cycle after the ack; the unit returns to IDLE.
- Ack arriving in the first req cycle is legal (minimum latency 2 cycles).
- Timeout: MEM_TIMEOUT cycles of req without ack drops req and pulses o_bus_err together with o_done. MDR is unchanged; the unit returns to IDLE.
- i_mem_ack outside MEM is ignored.

Test Plan:
- DATA_W=8, ADD 0xF0+0x20 -> o_result=0x10, carry=1, zero=0; then SUB 0x05-0x05 back-to-back -> result 0x00, carry=0, zero=1; o_done high on both consecutive cycles.
- MUL 0x12*0x10 -> o_ready low 8 cycles, o_done at cycle 9, result 0x20, carry=1; MUL 0x00*0xFF -> result 0, zero=1, carry=0; i_valid during busy is not accepted.
- MVI 0x5A to MM, then STORE_WORD op1=0x12 op2=0x34 with ack after 3 cycles -> addr 0x1234, we=1, wdata 0x5A, req held 3 cycles, o_done next cycle.
- LOAD_WORD with ack in the first cycle, rdata 0xC3 -> MDR=0xC3; MMDR to REGA -> o_rega=0xC3; flags unchanged from the prior ALU op.
- LOAD_WORD with no ack -> req drops after 16 cycles, o_bus_err and o_done pulse together, MDR is kept.
- HALT -> o_end_of_code pulse, o_ready stays 0 for 20 cycles. Reset asserted mid-MUL and mid-MEM -> o_mem_req drops at once, all outputs 0, o_ready=1.

Source files
------------

// File: rtl/mest_pro_exec_mc.sv
// mest_pro_exec_mc -- multi-cycle execute unit for the MESTPro core.
//
// Accepts one instruction per cycle from decode through a valid/ready
// handshake. ALU ops, moves and control ops finish in a single cycle.
// MULTIPLY runs an iterative shift-add for DATA_W cycles. LOAD_WORD and
// STORE_WORD use a req/ack memory port with a timeout. HALT parks the unit
// until reset.
//
// Ports:
//   clk, i_reset_n              clock, asynchronous active-low reset
//   i_valid / o_ready           instruction handshake (ready only in IDLE)
//   i_op_code, i_operand1/2     opcode and operands; operand2 also selects
//                               the move destination and the address low byte
//   i_load_reg                  source value for MLR
//   o_done                      one-cycle retire pulse
//   o_result, o_carry, o_zero   ALU result register and flags
//   o_jump, o_return_pc,
//   o_end_of_code,
//   o_output_enable             one-cycle pulses, coincident with o_done
//   o_output, o_rega, o_mdr     output register, register A, memory data reg
//   o_mem_req/we/addr/wdata     memory request port (wdata mirrors o_mdr)
//   i_mem_ack, i_mem_rdata      memory acknowledge and read data
//   o_bus_err                   one-cycle pulse on memory timeout
module mest_pro_exec_mc #(
  parameter int DATA_W      = 8,
  parameter int ADDR_W      = 2 * DATA_W,
  parameter int OPC_W       = 5,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              i_reset_n,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [OPC_W-1:0]  i_op_code,
  input  logic [DATA_W-1:0] i_operand1,
  input  logic [DATA_W-1:0] i_operand2,
  input  logic [DATA_W-1:0] i_load_reg,
  output logic              o_done,
  output logic [DATA_W-1:0] o_result,
  output logic              o_carry,
  output logic              o_zero,
  output logic              o_jump,
  output logic              o_return_pc,
  output logic              o_end_of_code,
  output logic              o_output_enable,
  output logic [DATA_W-1:0] o_output,
  output logic [DATA_W-1:0] o_rega,
  output logic [DATA_W-1:0] o_mdr,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic              i_mem_ack,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_bus_err
);

  localparam logic [OPC_W-1:0] OP_ADD        = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_SUB        = OPC_W'(1);
  localparam logic [OPC_W-1:0] OP_MULTIPLY   = OPC_W'(2);
  localparam logic [OPC_W-1:0] OP_AND        = OPC_W'(3);
  localparam logic [OPC_W-1:0] OP_OR         = OPC_W'(4);
  localparam logic [OPC_W-1:0] OP_XOR        = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_SROP1      = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_SLOP1      = OPC_W'(7);
  localparam logic [OPC_W-1:0] OP_NEGOP1     = OPC_W'(8);
  localparam logic [OPC_W-1:0] OP_JMP        = OPC_W'(9);
  localparam logic [OPC_W-1:0] OP_RET        = OPC_W'(10);
  localparam logic [OPC_W-1:0] OP_MVI        = OPC_W'(11);
  localparam logic [OPC_W-1:0] OP_MRA        = OPC_W'(12);
  localparam logic [OPC_W-1:0] OP_MLR        = OPC_W'(13);
  localparam logic [OPC_W-1:0] OP_MMDR       = OPC_W'(14);
  localparam logic [OPC_W-1:0] OP_MRR        = OPC_W'(15);
  localparam logic [OPC_W-1:0] OP_OUTPUT     = OPC_W'(16);
  localparam logic [OPC_W-1:0] OP_STORE_WORD = OPC_W'(17);
  localparam logic [OPC_W-1:0] OP_LOAD_WORD  = OPC_W'(18);
  localparam logic [OPC_W-1:0] OP_HALT       = OPC_W'(19);

  // Move destinations, selected by operand2.
  localparam logic [DATA_W-1:0] DST_OUT  = DATA_W'(0);
  localparam logic [DATA_W-1:0] DST_REGA = DATA_W'(1);
  localparam logic [DATA_W-1:0] DST_MM   = DATA_W'(2);

  localparam int CNT_W = $clog2(DATA_W + 1);
  localparam int TO_W  = $clog2(MEM_TIMEOUT + 1);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_MEM, S_HALTED} state_t;

  state_t                state_q, state_d;
  logic [DATA_W-1:0]     result_q, result_d;
  logic                  carry_q, carry_d, zero_q, zero_d;
  logic                  done_q, done_d, jump_q, jump_d, ret_q, ret_d;
  logic                  eoc_q, eoc_d, oen_q, oen_d, berr_q, berr_d;
  logic [DATA_W-1:0]     output_q, output_d, rega_q, rega_d, mdr_q, mdr_d;
  logic                  req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0]     addr_q, addr_d;
  logic [2*DATA_W-1:0]   mcand_q, mcand_d, acc_q, acc_d;
  logic [DATA_W-1:0]     mplier_q, mplier_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [TO_W-1:0]       tcnt_q, tcnt_d;

  // Scratch values for the IDLE decode.
  logic                  alu_en, alu_c, mv_en, mv_mm_ok;
  logic [DATA_W-1:0]     alu_res, mv_src;
  logic [DATA_W:0]       wide;
  logic [2*DATA_W-1:0]   acc_step;

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    carry_d  = carry_q;
    zero_d   = zero_q;
    done_d   = 1'b0;
    jump_d   = 1'b0;
    ret_d    = 1'b0;
    eoc_d    = 1'b0;
    oen_d    = 1'b0;
    berr_d   = 1'b0;
    output_d = output_q;
    rega_d   = rega_q;
    mdr_d    = mdr_q;
    req_d    = req_q;
    we_d     = we_q;
    addr_d   = addr_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    tcnt_d   = tcnt_q;
    alu_en   = 1'b0;
    alu_c    = 1'b0;
    alu_res  = '0;
    mv_en    = 1'b0;
    mv_mm_ok = 1'b1;
    mv_src   = '0;
    wide     = '0;
    acc_step = '0;

    unique case (state_q)
      S_IDLE: begin
        if (i_valid) begin
          done_d = 1'b1;
          case (i_op_code)
            OP_ADD: begin
              wide    = {1'b0, i_operand1} + {1'b0, i_operand2};
              alu_en  = 1'b1;
              alu_res = wide[DATA_W-1:0];
              alu_c   = wide[DATA_W];
            end
            OP_SUB: begin
              // The extra MSB of the widened difference is the borrow.
              wide    = {1'b0, i_operand1} - {1'b0, i_operand2};
              alu_en  = 1'b1;
              alu_res = wide[DATA_W-1:0];
              alu_c   = wide[DATA_W];
            end
            OP_AND: begin alu_en = 1'b1; alu_res = i_operand1 & i_operand2; end
            OP_OR:  begin alu_en = 1'b1; alu_res = i_operand1 | i_operand2; end
            OP_XOR: begin alu_en = 1'b1; alu_res = i_operand1 ^ i_operand2; end
            OP_SROP1: begin
              alu_en  = 1'b1;
              alu_res = i_operand1 >> 1;
              alu_c   = i_operand1[0];
            end
            OP_SLOP1: begin
              alu_en  = 1'b1;
              alu_res = i_operand1 << 1;
              alu_c   = i_operand1[DATA_W-1];
            end
            OP_NEGOP1: begin alu_en = 1'b1; alu_res = '0 - i_operand1; end
            OP_MVI:  begin mv_en = 1'b1; mv_src = i_operand1; end
            OP_MRA:  begin mv_en = 1'b1; mv_src = rega_q; end
            OP_MLR:  begin mv_en = 1'b1; mv_src = i_load_reg; end
            OP_MMDR: begin mv_en = 1'b1; mv_src = mdr_q; mv_mm_ok = 1'b0; end
            OP_MRR:  begin mv_en = 1'b1; mv_src = result_q; end
            OP_JMP:    jump_d = 1'b1;
            OP_RET:    ret_d  = 1'b1;
            OP_OUTPUT: oen_d  = 1'b1;
            OP_HALT: begin
              eoc_d   = 1'b1;
              state_d = S_HALTED;
            end
            OP_MULTIPLY: begin
              done_d   = 1'b0;
              mcand_d  = {{DATA_W{1'b0}}, i_operand1};
              mplier_d = i_operand2;
              acc_d    = '0;
              cnt_d    = '0;
              state_d  = S_MUL;
            end
            OP_LOAD_WORD, OP_STORE_WORD: begin
              done_d  = 1'b0;
              addr_d  = ADDR_W'({i_operand1, i_operand2});
              we_d    = (i_op_code == OP_STORE_WORD);
              req_d   = 1'b1;
              tcnt_d  = '0;
              state_d = S_MEM;
            end
            default: ;
          endcase

          if (alu_en) begin
            result_d = alu_res;
            carry_d  = alu_c;
            zero_d   = (alu_res == '0);
          end
          if (mv_en) begin
            if (i_operand2 == DST_OUT)                  output_d = mv_src;
            else if (i_operand2 == DST_REGA)            rega_d   = mv_src;
            else if (i_operand2 == DST_MM && mv_mm_ok)  mdr_d    = mv_src;
          end
        end
      end

      S_MUL: begin
        acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        // Flags come from the step's sum directly so retire is not delayed.
        if (cnt_q == CNT_W'(DATA_W - 1)) begin
          result_d = acc_step[DATA_W-1:0];
          carry_d  = |acc_step[2*DATA_W-1:DATA_W];
          zero_d   = (acc_step == '0);
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end

      S_MEM: begin
        if (i_mem_ack) begin
          if (!we_q) mdr_d = i_mem_rdata;
          req_d   = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (tcnt_q == TO_W'(MEM_TIMEOUT - 1)) begin
          req_d   = 1'b0;
          we_d    = 1'b0;
          done_d  = 1'b1;
          berr_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end

      S_HALTED: ;

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= S_IDLE;
      result_q <= '0;
      carry_q  <= 1'b0;
      zero_q   <= 1'b0;
      done_q   <= 1'b0;
      jump_q   <= 1'b0;
      ret_q    <= 1'b0;
      eoc_q    <= 1'b0;
      oen_q    <= 1'b0;
      berr_q   <= 1'b0;
      output_q <= '0;
      rega_q   <= '0;
      mdr_q    <= '0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      tcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      carry_q  <= carry_d;
      zero_q   <= zero_d;
      done_q   <= done_d;
      jump_q   <= jump_d;
      ret_q    <= ret_d;
      eoc_q    <= eoc_d;
      oen_q    <= oen_d;
      berr_q   <= berr_d;
      output_q <= output_d;
      rega_q   <= rega_d;
      mdr_q    <= mdr_d;
      req_q    <= req_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      tcnt_q   <= tcnt_d;
    end
  end

  assign o_ready         = (state_q == S_IDLE);
  assign o_done          = done_q;
  assign o_result        = result_q;
  assign o_carry         = carry_q;
  assign o_zero          = zero_q;
  assign o_jump          = jump_q;
  assign o_return_pc     = ret_q;
  assign o_end_of_code   = eoc_q;
  assign o_output_enable = oen_q;
  assign o_output        = output_q;
  assign o_rega          = rega_q;
  assign o_mdr           = mdr_q;
  assign o_mem_req       = req_q;
  assign o_mem_we        = we_q;
  assign o_mem_addr      = addr_q;
  assign o_mem_wdata     = mdr_q;
  assign o_bus_err       = berr_q;

endmodule

// File: tb/tb_mest_pro_exec_mc.sv
// Self-checking bench for mest_pro_exec_mc (DATA_W=8, MEM_TIMEOUT=16).
module tb_mest_pro_exec_mc;
  localparam int W  = 8;
  localparam int TO = 16;

  localparam logic [4:0] OP_ADD = 5'd0, OP_SUB = 5'd1, OP_MULTIPLY = 5'd2,
    OP_AND = 5'd3, OP_OR = 5'd4, OP_XOR = 5'd5, OP_SROP1 = 5'd6, OP_SLOP1 = 5'd7,
    OP_NEGOP1 = 5'd8, OP_JMP = 5'd9, OP_RET = 5'd10, OP_MVI = 5'd11, OP_MRA = 5'd12,
    OP_MLR = 5'd13, OP_MMDR = 5'd14, OP_MRR = 5'd15, OP_OUTPUT = 5'd16,
    OP_STORE_WORD = 5'd17, OP_LOAD_WORD = 5'd18, OP_HALT = 5'd19;

  logic clk, i_reset_n, i_valid, o_ready, o_done, o_carry, o_zero;
  logic o_jump, o_return_pc, o_end_of_code, o_output_enable;
  logic o_mem_req, o_mem_we, i_mem_ack, o_bus_err;
  logic [4:0]   i_op_code;
  logic [W-1:0] i_operand1, i_operand2, i_load_reg, o_result, o_output, o_rega, o_mdr;
  logic [W-1:0] o_mem_wdata, i_mem_rdata;
  logic [2*W-1:0] o_mem_addr;

  mest_pro_exec_mc #(.DATA_W(W), .ADDR_W(2*W), .OPC_W(5), .MEM_TIMEOUT(TO)) dut (
    .clk(clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_op_code(i_op_code), .i_operand1(i_operand1), .i_operand2(i_operand2),
    .i_load_reg(i_load_reg), .o_done(o_done), .o_result(o_result),
    .o_carry(o_carry), .o_zero(o_zero), .o_jump(o_jump), .o_return_pc(o_return_pc),
    .o_end_of_code(o_end_of_code), .o_output_enable(o_output_enable),
    .o_output(o_output), .o_rega(o_rega), .o_mdr(o_mdr), .o_mem_req(o_mem_req),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr), .o_mem_wdata(o_mem_wdata),
    .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata), .o_bus_err(o_bus_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Reference model: architectural state and expected pulses.
  logic [W-1:0] m_res, m_rega, m_out, m_mdr;
  logic m_c, m_z, e_jump, e_ret, e_eoc, e_oen, e_berr;

  function automatic void model_clear();
    m_res = '0; m_rega = '0; m_out = '0; m_mdr = '0; m_c = 1'b0; m_z = 1'b0;
  endfunction

  function automatic void set_alu(int r, bit c);
    m_res = 8'(r % 256);
    m_c   = c;
    m_z   = ((r % 256) == 0);
  endfunction

  function automatic void mv(int dst, logic [W-1:0] v, bit mm_ok);
    if (dst == 0) m_out = v;
    else if (dst == 1) m_rega = v;
    else if (dst == 2 && mm_ok) m_mdr = v;
  endfunction

  function automatic void model_op(logic [4:0] op, int a, int b, int lr);
    int p;
    e_jump = 0; e_ret = 0; e_eoc = 0; e_oen = 0; e_berr = 0;
    case (op)
      OP_ADD:    set_alu(a + b, (a + b) > 255);
      OP_SUB:    set_alu(a - b + 256, a < b);
      OP_AND:    set_alu(a & b, 0);
      OP_OR:     set_alu(a | b, 0);
      OP_XOR:    set_alu(a ^ b, 0);
      OP_SROP1:  set_alu(a / 2, (a % 2) == 1);
      OP_SLOP1:  set_alu(a * 2, a >= 128);
      OP_NEGOP1: set_alu(256 - a, 0);
      OP_MULTIPLY: begin
        p = a * b;
        m_res = 8'(p % 256);
        m_c   = (p >= 256);
        m_z   = (p == 0);
      end
      OP_MVI:    mv(b, 8'(a), 1);
      OP_MRA:    mv(b, m_rega, 1);
      OP_MLR:    mv(b, 8'(lr), 1);
      OP_MMDR:   mv(b, m_mdr, 0);
      OP_MRR:    mv(b, m_res, 1);
      OP_JMP:    e_jump = 1;
      OP_RET:    e_ret = 1;
      OP_OUTPUT: e_oen = 1;
      OP_HALT:   e_eoc = 1;
      default: ;
    endcase
  endfunction

  task automatic check_state(input string tag, input bit exp_ready);
    chk({tag, ".result"}, o_result, m_res);
    chk({tag, ".carry"},  o_carry,  m_c);
    chk({tag, ".zero"},   o_zero,   m_z);
    chk({tag, ".rega"},   o_rega,   m_rega);
    chk({tag, ".output"}, o_output, m_out);
    chk({tag, ".mdr"},    o_mdr,    m_mdr);
    chk({tag, ".ready"},  o_ready,  exp_ready);
  endtask

  // Issue one instruction and follow it to retire. ackdly: req cycle in which
  // ack is returned (1 = first req cycle); 0 = never (timeout).
  task automatic run_op(input logic [4:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] lr, input int ackdly, input logic [W-1:0] rdata,
                        input logic stray_ack);
    int k;
    bit is_mem, acked;
    is_mem = (op == OP_STORE_WORD) || (op == OP_LOAD_WORD);
    acked  = (ackdly >= 1) && (ackdly <= TO);
    i_op_code = op; i_operand1 = a; i_operand2 = b; i_load_reg = lr;
    i_valid = 1'b1; i_mem_ack = stray_ack;
    @(posedge clk); #1;
    i_valid = 1'b0; i_mem_ack = 1'b0;
    k = 1;
    if (op == OP_MULTIPLY) begin
      while (!o_done && k < 40) begin
        chk("mul_busy_ready", o_ready, 0);
        i_valid = 1'b1; i_op_code = OP_HALT;  // must be ignored while busy
        @(posedge clk); #1;
        k++;
      end
      i_valid = 1'b0;
      chk("mul_latency", k, W + 1);
    end else if (is_mem) begin
      while (!o_done && k < 40) begin
        chk("mem_req", o_mem_req, 1);
        chk("mem_addr", o_mem_addr, {a, b});
        chk("mem_we", o_mem_we, op == OP_STORE_WORD);
        chk("mem_wdata", o_mem_wdata, m_mdr);
        chk("mem_busy_ready", o_ready, 0);
        i_valid = 1'b1; i_op_code = OP_HALT;
        if (k == ackdly) begin i_mem_ack = 1'b1; i_mem_rdata = rdata; end
        @(posedge clk); #1;
        i_mem_ack = 1'b0;
        k++;
      end
      i_valid = 1'b0;
      chk("mem_req_drop", o_mem_req, 0);
      chk("mem_latency", k, acked ? ackdly + 1 : TO + 1);
    end
    model_op(op, a, b, lr);
    if (is_mem) begin
      e_berr = !acked;
      if (acked && op == OP_LOAD_WORD) m_mdr = rdata;
    end
    chk("done", o_done, 1);
    chk("jump", o_jump, e_jump);
    chk("return_pc", o_return_pc, e_ret);
    chk("end_of_code", o_end_of_code, e_eoc);
    chk("output_enable", o_output_enable, e_oen);
    chk("bus_err", o_bus_err, e_berr);
    check_state("op", op != OP_HALT);
  endtask

  task automatic reset_check(input string tag);
    i_reset_n = 1'b0;
    #1;
    chk({tag, ".req"},    o_mem_req, 0);
    chk({tag, ".ready"},  o_ready, 1);
    chk({tag, ".done"},   o_done, 0);
    chk({tag, ".we"},     o_mem_we, 0);
    chk({tag, ".addr"},   o_mem_addr, 0);
    chk({tag, ".berr"},   o_bus_err, 0);
    chk({tag, ".eoc"},    o_end_of_code, 0);
    model_clear();
    check_state(tag, 1);
    i_valid = 1'b0; i_mem_ack = 1'b0;
    @(posedge clk); #1;
    i_reset_n = 1'b1;
  endtask

  typedef struct {
    logic [4:0]   op;
    logic [W-1:0] a, b;
    logic [W-1:0] er;
    logic         ec, ez;
  } vec_t;

  vec_t tbl[15];

  initial begin
    #1000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    logic [4:0] op;
    logic [W-1:0] a, b;
    int dly;

    tbl[0]  = '{OP_ADD,      8'hF0, 8'h20, 8'h10, 1'b1, 1'b0};
    tbl[1]  = '{OP_SUB,      8'h05, 8'h05, 8'h00, 1'b0, 1'b1};
    tbl[2]  = '{OP_SUB,      8'h03, 8'h05, 8'hFE, 1'b1, 1'b0};
    tbl[3]  = '{OP_AND,      8'hF0, 8'h0F, 8'h00, 1'b0, 1'b1};
    tbl[4]  = '{OP_OR,       8'hF0, 8'h0F, 8'hFF, 1'b0, 1'b0};
    tbl[5]  = '{OP_XOR,      8'hAA, 8'hFF, 8'h55, 1'b0, 1'b0};
    tbl[6]  = '{OP_SLOP1,    8'h81, 8'h00, 8'h02, 1'b1, 1'b0};
    tbl[7]  = '{OP_SROP1,    8'h81, 8'h00, 8'h40, 1'b1, 1'b0};
    tbl[8]  = '{OP_NEGOP1,   8'h01, 8'h00, 8'hFF, 1'b0, 1'b0};
    tbl[9]  = '{OP_NEGOP1,   8'h00, 8'h00, 8'h00, 1'b0, 1'b1};
    tbl[10] = '{OP_MULTIPLY, 8'h12, 8'h10, 8'h20, 1'b1, 1'b0};
    tbl[11] = '{OP_MULTIPLY, 8'h00, 8'hFF, 8'h00, 1'b0, 1'b1};
    tbl[12] = '{OP_MULTIPLY, 8'h10, 8'h10, 8'h00, 1'b1, 1'b0};
    tbl[13] = '{OP_MULTIPLY, 8'hFF, 8'hFF, 8'h01, 1'b1, 1'b0};
    tbl[14] = '{OP_MVI,      8'h5A, 8'h00, 8'h01, 1'b1, 1'b0};  // flags held

    i_reset_n = 1'b0; i_valid = 1'b0; i_op_code = '0; i_operand1 = '0;
    i_operand2 = '0; i_load_reg = '0; i_mem_ack = 1'b0; i_mem_rdata = '0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    reset_check("reset");

    // Back-to-back ADD then SUB: done on two consecutive cycles.
    i_op_code = OP_ADD; i_operand1 = 8'hF0; i_operand2 = 8'h20; i_valid = 1'b1;
    @(posedge clk); #1;
    chk("b2b.add.done", o_done, 1);
    chk("b2b.add.result", o_result, 8'h10);
    chk("b2b.add.carry", o_carry, 1);
    chk("b2b.add.zero", o_zero, 0);
    i_op_code = OP_SUB; i_operand1 = 8'h05; i_operand2 = 8'h05;
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("b2b.sub.done", o_done, 1);
    chk("b2b.sub.result", o_result, 8'h00);
    chk("b2b.sub.carry", o_carry, 0);
    chk("b2b.sub.zero", o_zero, 1);
    model_op(OP_ADD, 8'hF0, 8'h20, 0);
    model_op(OP_SUB, 8'h05, 8'h05, 0);

    for (int i = 0; i < 15; i++) begin
      run_op(tbl[i].op, tbl[i].a, tbl[i].b, 8'h00, 0, 8'h00, 1'b0);
      chk("tbl.result", o_result, tbl[i].er);
      chk("tbl.carry", o_carry, tbl[i].ec);
      chk("tbl.zero", o_zero, tbl[i].ez);
    end

    // Memory sequences.
    run_op(OP_MVI, 8'h5A, 8'h02, 8'h00, 0, 8'h00, 1'b0);
    chk("mvi_mm.mdr", o_mdr, 8'h5A);
    run_op(OP_STORE_WORD, 8'h12, 8'h34, 8'h00, 3, 8'h00, 1'b0);
    run_op(OP_LOAD_WORD, 8'hAB, 8'hCD, 8'h00, 1, 8'hC3, 1'b0);
    chk("load.mdr", o_mdr, 8'hC3);
    run_op(OP_MMDR, 8'h00, 8'h01, 8'h00, 0, 8'h00, 1'b0);
    chk("mmdr.rega", o_rega, 8'hC3);
    run_op(OP_LOAD_WORD, 8'h00, 8'h01, 8'h00, 0, 8'h77, 1'b0);
    chk("timeout.mdr", o_mdr, 8'hC3);

    // Randomised mix against the model.
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 19) == 0) op = 5'($urandom_range(20, 31));
      else op = 5'($urandom_range(0, 18));
      a = 8'($urandom);
      b = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      dly = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, 5));
      run_op(op, a, b, 8'($urandom), dly, 8'($urandom), 1'($urandom));
    end

    // Reset in the middle of a multiply.
    i_op_code = OP_MULTIPLY; i_operand1 = 8'h33; i_operand2 = 8'h44; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset_check("rst_mul");

    // Reset while a memory request is outstanding.
    run_op(OP_MVI, 8'h99, 8'h02, 8'h00, 0, 8'h00, 1'b0);
    i_op_code = OP_LOAD_WORD; i_operand1 = 8'h01; i_operand2 = 8'h02; i_valid = 1'b1;
    @(posedge clk); #1;
    i_valid = 1'b0;
    chk("rst_mem.req_before", o_mem_req, 1);
    @(posedge clk); #2;
    reset_check("rst_mem");

    // HALT parks the unit until reset.
    run_op(OP_ADD, 8'h01, 8'h02, 8'h00, 0, 8'h00, 1'b0);
    run_op(OP_HALT, 8'h00, 8'h00, 8'h00, 0, 8'h00, 1'b0);
    for (int i = 0; i < 20; i++) begin
      i_valid = 1'b1; i_op_code = OP_ADD; i_operand1 = 8'hFF; i_operand2 = 8'hFF;
      i_mem_ack = 1'b1;
      @(posedge clk); #1;
      chk("halt.ready", o_ready, 0);
      chk("halt.done", o_done, 0);
    end
    i_valid = 1'b0; i_mem_ack = 1'b0;
    check_state("halt.hold", 0);
    reset_check("rst_halt");
    run_op(OP_SUB, 8'h10, 8'h01, 8'h00, 0, 8'h00, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
